// File: rtl/divisor_6b3b.sv
// divisor_6b3b: multi-cycle restoring divider, 6-bit dividend by 3-bit divisor, one quotient bit per cycle.
module divisor_6b3b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] dividend,
  input  logic [2:0] divisor,
  output logic [5:0] quotient,
  output logic [2:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       dz
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [5:0] dvd;
  logic [2:0] dvs, cnt, rem, rem_n;
  logic [3:0] partial;
  logic       ge, accept;
  always_comb begin
    accept  = start && state != CALC;
    partial = {rem, dvd[5]};
    ge      = partial >= {1'b0, dvs};
    rem_n   = ge ? 3'(partial - {1'b0, dvs}) : partial[2:0];
    state_n = accept ? (divisor == 3'd0 ? DONE : CALC)
            : state == CALC ? (cnt == 3'd0 ? DONE : CALC) : IDLE;
  end
  assign busy = state == CALC;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && divisor == 3'd0) begin
        quotient  <= 6'h3f;
        remainder <= 3'd0;
        dz        <= 1'b1;
      end else if (accept) begin
        dvd <= dividend;
        dvs <= divisor;
        rem <= 3'd0;
        cnt <= 3'd5;
        dz  <= 1'b0;
      end else if (state == CALC) begin
        dvd       <= {dvd[4:0], 1'b0};
        rem       <= rem_n;
        cnt       <= cnt - 3'd1;
        quotient  <= {quotient[4:0], ge};
        remainder <= rem_n;
      end
    end
  end
endmodule
